// File: rtl/int_bus_arbiter.sv
`timescale 1ns/1ps
// int_bus_arbiter
// Shares one register-file bus (AW-bit address, DW-bit data) between NUM_M
// masters. Round-robin arbitration, one RELEASE turnaround cycle between owners,
// and an optional hold-time limit that revokes a grant when others are waiting.
//
// Handshake: a master raises m_req (level) and keeps it high for the whole
// access. m_gnt[i] rises one clock after m_req[i] is sampled in IDLE and stays
// high until the master drops m_req or the hold limit revokes it. Strobes
// (m_write/m_read) reach the slave only from the current owner while busy=1.
// Dropping m_req ends the access on the next edge; the owner may still strobe
// in the cycle where it drops m_req.
module int_bus_arbiter #(
  parameter int NUM_M      = 2,
  parameter int AW         = 16,
  parameter int DW         = 8,
  parameter int HOLD_LIMIT = 1024,
  parameter int TIMEOUT_EN = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_M-1:0]    m_req,
  output logic [NUM_M-1:0]    m_gnt,
  input  logic [NUM_M*AW-1:0] m_address,
  input  logic [NUM_M*DW-1:0] m_wr_data,
  input  logic [NUM_M-1:0]    m_write,
  input  logic [NUM_M-1:0]    m_read,
  output logic [DW-1:0]       m_rd_data,
  output logic [AW-1:0]       s_address,
  output logic [DW-1:0]       s_wr_data,
  output logic                s_write,
  output logic                s_read,
  input  logic [DW-1:0]       s_rd_data,
  output logic [2:0]          owner,
  output logic                busy,
  output logic                timeout,
  output logic [1:0]          state_dbg
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int HW = $clog2(HOLD_LIMIT);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_LIMIT - 1);
  localparam logic [NUM_M-1:0] ONE_M = NUM_M'(1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [NUM_M-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             timeout_q, timeout_d;

  logic             sel_found;
  logic [IW-1:0]    sel_idx;
  logic [IW-1:0]    ptr_after;
  logic             owner_req;
  logic             owner_wr;
  logic             owner_rd;
  logic             others_waiting;

  // Round-robin pick: lowest requester at or after the pointer, else lowest overall.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if (m_req[i]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if (m_req[i] && (IW'(i) >= ptr_q)) begin
        sel_idx = IW'(i);
      end
    end
  end

  // Owner-side mux: the owner's request, strobes and bus fields.
  always_comb begin
    owner_req      = 1'b0;
    owner_wr       = 1'b0;
    owner_rd       = 1'b0;
    others_waiting = 1'b0;
    s_address      = '0;
    s_wr_data      = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (owner_q == IW'(i)) begin
        owner_req = m_req[i];
        owner_wr  = m_write[i];
        owner_rd  = m_read[i];
        s_address = m_address[i*AW +: AW];
        s_wr_data = m_wr_data[i*DW +: DW];
      end else if (m_req[i]) begin
        others_waiting = 1'b1;
      end
    end
  end

  // Priority moves to the master after the outgoing owner, wrapping at NUM_M-1.
  always_comb begin
    ptr_after = (owner_q == IW'(NUM_M - 1)) ? '0 : owner_q + 1'b1;
  end

  // Next-state logic for IDLE -> GRANT -> RELEASE -> IDLE.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          state_d = S_GRANT;
          gnt_d   = ONE_M << sel_idx;
          owner_d = sel_idx;
          hold_d  = '0;
        end
      end
      S_GRANT: begin
        if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
        end
        if (!owner_req) begin
          state_d = S_RELEASE;
          gnt_d   = '0;
          ptr_d   = ptr_after;
        end else if ((TIMEOUT_EN != 0) && (hold_q == HOLD_MAX) && others_waiting) begin
          // Hold limit reached with someone queued: revoke, owner re-arbitrates later.
          state_d   = S_RELEASE;
          gnt_d     = '0;
          ptr_d     = ptr_after;
          timeout_d = 1'b1;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State registers; reset drops any grant immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  // Slave strobes only flow in GRANT; write wins over read.
  always_comb begin
    busy      = (state_q == S_GRANT);
    s_write   = busy & owner_wr;
    s_read    = busy & owner_rd & ~owner_wr;
    m_gnt     = gnt_q;
    owner     = 3'(owner_q);
    timeout   = timeout_q;
    m_rd_data = s_rd_data;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_int_bus_arbiter.sv
`timescale 1ns/1ps
// Bench for int_bus_arbiter: directed scenarios followed by random traffic,
// all checked against a behavioural bus-ownership model.
module tb_int_bus_arbiter;

  localparam int NM = 2;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int HL = 8;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [NM-1:0]    m_req, m_gnt, m_write, m_read;
  logic [NM*AW-1:0] m_address;
  logic [NM*DW-1:0] m_wr_data;
  logic [DW-1:0]    m_rd_data, s_wr_data, s_rd_data;
  logic [AW-1:0]    s_address;
  logic             s_write, s_read, busy, timeout;
  logic [2:0]       owner;
  logic [1:0]       state_dbg;

  int n_assert = 0;
  int n_fail   = 0;

  int_bus_arbiter #(
    .NUM_M(NM), .AW(AW), .DW(DW), .HOLD_LIMIT(HL), .TIMEOUT_EN(1)
  ) u_dut (
    .clock(clock), .reset(reset),
    .m_req(m_req), .m_gnt(m_gnt),
    .m_address(m_address), .m_wr_data(m_wr_data),
    .m_write(m_write), .m_read(m_read),
    .m_rd_data(m_rd_data),
    .s_address(s_address), .s_wr_data(s_wr_data),
    .s_write(s_write), .s_read(s_read), .s_rd_data(s_rd_data),
    .owner(owner), .busy(busy), .timeout(timeout),
    .state_dbg(state_dbg)
  );

  // reference model: who owns the bus, turnaround left, next priority
  int mdl_own;    // -1 when nobody owns the bus
  int mdl_last;   // last master that was granted
  int mdl_cool;   // idle turnaround cycles still to serve before arbitrating
  int mdl_prio;   // master with highest priority at the next arbitration
  int mdl_held;   // grant cycles already completed by the current owner
  bit mdl_to;

  task automatic mdl_reset();
    mdl_own  = -1;
    mdl_last = 0;
    mdl_cool = 0;
    mdl_prio = 0;
    mdl_held = 0;
    mdl_to   = 1'b0;
  endtask

  // one clock edge of the model, using the inputs present at that edge
  task automatic mdl_update();
    logic [NM-1:0] others;
    mdl_to = 1'b0;
    if (!reset) begin
      mdl_reset();
      return;
    end
    if (mdl_own >= 0) begin
      others = m_req;
      others[mdl_own] = 1'b0;
      if (!m_req[mdl_own]) begin
        mdl_prio = (mdl_own + 1) % NM;
        mdl_own  = -1;
        mdl_cool = 1;
      end else if (mdl_held >= HL - 1 && others != 0) begin
        mdl_prio = (mdl_own + 1) % NM;
        mdl_own  = -1;
        mdl_cool = 1;
        mdl_to   = 1'b1;
      end else begin
        mdl_held++;
      end
    end else if (mdl_cool > 0) begin
      mdl_cool--;
    end else if (m_req != 0) begin
      for (int k = 0; k < NM; k++) begin
        int c;
        c = (mdl_prio + k) % NM;
        if (m_req[c]) begin
          mdl_own  = c;
          mdl_last = c;
          mdl_held = 0;
          break;
        end
      end
    end
  endtask

  // scoreboard compare
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic [NM-1:0] eg;
    logic ew, er;
    eg = '0;
    ew = 1'b0;
    er = 1'b0;
    if (mdl_own >= 0) begin
      eg[mdl_own] = 1'b1;
      ew = m_write[mdl_own];
      er = m_read[mdl_own] & ~m_write[mdl_own];
    end
    chk("m_gnt", 32'(m_gnt), 32'(eg));
    chk("busy", 32'(busy), 32'(mdl_own >= 0));
    chk("s_write", 32'(s_write), 32'(ew));
    chk("s_read", 32'(s_read), 32'(er));
    chk("timeout", 32'(timeout), 32'(mdl_to));
    chk("m_rd_data", 32'(m_rd_data), 32'(s_rd_data));
    if (mdl_own >= 0) begin
      chk("owner", 32'(owner), 32'(mdl_last));
      chk("s_address", 32'(s_address), 32'(m_address[mdl_last*AW +: AW]));
      chk("s_wr_data", 32'(s_wr_data), 32'(m_wr_data[mdl_last*DW +: DW]));
    end
  endtask

  // driver: check the current cycle, then advance one clock
  task automatic step();
    #1;
    check_outputs();
    @(posedge clock);
    mdl_update();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    m_req     = '0;
    m_write   = '0;
    m_read    = '0;
    m_address = '0;
    m_wr_data = '0;
    s_rd_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    #1;
    mdl_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  int n01, nzero, nto;
  bit got10;
  int bc;
  logic [NM-1:0] prev_g;
  int order[$];

  initial begin
    // reset state
    reset = 1'b0;
    idle_inputs();
    mdl_reset();
    @(negedge clock);
    #1;
    chk("rst_gnt", 32'(m_gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_s_write", 32'(s_write), 32'h0);
    chk("rst_s_read", 32'(s_read), 32'h0);
    @(negedge clock);
    reset = 1'b1;

    // 1) single write by master 0, granted one clock after request
    m_req = 2'b01;
    m_write = 2'b01;
    m_address = 32'h0000_0010;
    m_wr_data = 16'h00A5;
    step();
    #1;
    chk("t1_gnt", 32'(m_gnt), 32'h1);
    chk("t1_s_write", 32'(s_write), 32'h1);
    chk("t1_s_address", 32'(s_address), 32'h10);
    chk("t1_s_wr_data", 32'(s_wr_data), 32'hA5);
    m_req = 2'b00;
    m_write = 2'b00;
    repeat (3) step();

    // 2) both request right after reset: master 0 first, then 2-cycle gap
    do_reset();
    m_req = 2'b11;
    step();
    #1;
    chk("t2_first", 32'(m_gnt), 32'h1);
    repeat (2) step();
    m_req = 2'b10;
    step();
    #1;
    chk("t2_gap0", 32'(m_gnt), 32'h0);
    step();
    #1;
    chk("t2_gap1", 32'(m_gnt), 32'h0);
    step();
    #1;
    chk("t2_second", 32'(m_gnt), 32'h2);
    m_req = 2'b00;
    repeat (3) step();

    // 3) continuous re-requests with 2-cycle bursts: grants alternate
    bc = 0;
    prev_g = '0;
    order.delete();
    for (int c = 0; c < 40; c++) begin
      m_req = 2'b11;
      if (m_gnt != 0) begin
        if (prev_g == 0) order.push_back(m_gnt[1] ? 1 : 0);
        bc++;
        if (bc >= 2) m_req = m_req & ~m_gnt;
      end else begin
        bc = 0;
      end
      prev_g = m_gnt;
      step();
    end
    chk("t3_grant_count", 32'(order.size() >= 4), 32'h1);
    for (int i = 0; i < order.size(); i++) begin
      chk("t3_order", 32'(order[i]), 32'(i % 2));
    end
    m_req = 2'b00;
    repeat (4) step();

    // 4) hold limit: master 0 holds, master 1 waits -> revoke after HL cycles
    do_reset();
    m_req = 2'b01;
    step();
    m_req = 2'b11;
    n01 = 0;
    nzero = 0;
    nto = 0;
    got10 = 1'b0;
    for (int c = 0; c < 30 && !got10; c++) begin
      if (m_gnt == 2'b01) n01++;
      else if (m_gnt == 2'b00) nzero++;
      else if (m_gnt == 2'b10) got10 = 1'b1;
      if (timeout) nto++;
      if (!got10) step();
    end
    chk("t4_got10", 32'(got10), 32'h1);
    chk("t4_hold_cycles", 32'(n01), 32'(HL));
    chk("t4_gap_cycles", 32'(nzero), 32'h2);
    chk("t4_timeout_pulses", 32'(nto), 32'h1);
    m_req = 2'b00;
    repeat (3) step();
    // master 1 idle: owner keeps the bus well past the limit
    m_req = 2'b01;
    step();
    n01 = 0;
    nto = 0;
    for (int c = 0; c < 20; c++) begin
      if (m_gnt == 2'b01) n01++;
      if (timeout) nto++;
      step();
    end
    chk("t4_kept_cycles", 32'(n01), 32'd20);
    chk("t4_no_timeout", 32'(nto), 32'h0);

    // 5) non-owner strobes never reach the slave
    m_address = 32'h1234_0040;
    m_wr_data = 16'h5A3C;
    m_write = 2'b10;
    m_read = 2'b10;
    #1;
    chk("t5_block_write", 32'(s_write), 32'h0);
    chk("t5_block_read", 32'(s_read), 32'h0);
    step();
    m_write = 2'b01;
    m_read = 2'b01;
    #1;
    chk("t5_write_wins_w", 32'(s_write), 32'h1);
    chk("t5_write_wins_r", 32'(s_read), 32'h0);
    step();
    m_write = 2'b00;
    m_read = 2'b11;
    s_rd_data = 8'h9E;
    #1;
    chk("t5_owner_read", 32'(s_read), 32'h1);
    chk("t5_rd_data", 32'(m_rd_data), 32'h9E);
    step();

    // 6) reset mid write burst drops grant and strobe at once
    m_read = 2'b00;
    m_write = 2'b01;
    step();
    #3;
    reset = 1'b0;
    #1;
    chk("t6_gnt", 32'(m_gnt), 32'h0);
    chk("t6_s_write", 32'(s_write), 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);
    mdl_reset();
    @(negedge clock);
    reset = 1'b1;
    m_write = 2'b00;
    m_req = 2'b10;
    step();
    #1;
    chk("t6_regrant", 32'(m_gnt), 32'h2);
    m_req = 2'b00;
    repeat (3) step();

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NM; i++) begin
        if ($urandom_range(0, 9) == 0) m_req[i] = ~m_req[i];
      end
      m_write   = NM'($urandom_range(0, 3));
      m_read    = NM'($urandom_range(0, 3));
      m_address = $urandom;
      m_wr_data = 16'($urandom);
      s_rd_data = 8'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
